// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/flush controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller FSM state encoding, the scoreboard entry layout,
// the scoreboard stage indices and the single-entry source-match helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sb_entry_t;

    // Entry i mirrors the instruction held in ID_REG, REG_EX, EX_MEM.
    localparam int SB_REG   = 0;
    localparam int SB_EX    = 1;
    localparam int SB_MEM   = 2;
    localparam int SB_DEPTH = 3;

    // $0 is hard-wired zero, so reading it can never be a stale read.
    function automatic logic entry_match(input sb_entry_t e, input logic [4:0] r);
        return e.valid && (r != 5'd0) && (e.dest == r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight register-write scoreboard: 3-entry shift (REG, EX, MEM) plus source compare.
// Latency: match outputs are combinational from registered entries; entries update every edge.
// Backpressure: none; i_bubble inserts an empty REG entry, i_flush empties every entry.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_flush                   taken branch: all entries load invalid
//   i_bubble                  stall: REG loads invalid, older entries still shift
//   i_new_vld, i_new_dest     entry written into REG when ID advances
//   i_rs, i_rt                ID-stage source registers to compare
//   o_rs_match, o_rt_match    source equals a valid entry in the check set
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_flush,
    input  logic       i_bubble,
    input  logic       i_new_vld,
    input  logic [4:0] i_new_dest,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    output logic       o_rs_match,
    output logic       o_rt_match
);

    sb_entry_t r_sb [SB_DEPTH];

    // Without a WB bypass the producer is still unwritten while it sits in
    // MEM's successor slot, so MEM must also be part of the check set.
    logic w_chk_mem;
    assign w_chk_mem = (WB_BYPASS == 0);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_sb[SB_REG] <= '0;
            r_sb[SB_EX]  <= '0;
            r_sb[SB_MEM] <= '0;
        end else begin
            r_sb[SB_MEM] <= r_sb[SB_EX];
            r_sb[SB_EX]  <= r_sb[SB_REG];
            if (i_bubble) begin
                r_sb[SB_REG] <= '0;
            end else begin
                r_sb[SB_REG].valid <= i_new_vld;
                r_sb[SB_REG].dest  <= i_new_dest;
            end
        end
    end

    assign o_rs_match = entry_match(r_sb[SB_REG], i_rs)
                      | entry_match(r_sb[SB_EX], i_rs)
                      | (w_chk_mem & entry_match(r_sb[SB_MEM], i_rs));

    assign o_rt_match = entry_match(r_sb[SB_REG], i_rt)
                      | entry_match(r_sb[SB_EX], i_rt)
                      | (w_chk_mem & entry_match(r_sb[SB_MEM], i_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller for the IF-ID-REG-EX-MEM-WB pipeline with no forwarding.
// Latency: all control outputs are combinational (Mealy) and act on the next rising edge.
// Backpressure: stalls PC and IF_ID while an ID consumer would read a stale register.
//
// Ports:
//   i_clk, i_reset                     clock, synchronous active-high reset
//   i_id_valid, i_id_rs, i_id_rt,      ID-stage instruction: validity, sources,
//   i_id_uses_rt, i_id_dest,           whether rt is read, destination and
//   i_id_reg_write                     whether it writes the register file
//   i_mem_branch_taken                 branch resolved taken in MEM
//   o_pc_hold, o_if_id_hold            hold PC / IF_ID this edge
//   o_id_reg_bubble                    ID_REG loads zero controls
//   o_flush_*                          named pipeline register loads zero controls
//   o_pc_redirect                      PC loads the branch target
//   o_stall_count, o_flush_count       saturating performance counters
//   o_ctrl_state                       current FSM state (debug)
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic [4:0]       i_id_dest,
    input  logic             i_id_reg_write,
    input  logic             i_mem_branch_taken,
    output logic             o_pc_hold,
    output logic             o_if_id_hold,
    output logic             o_id_reg_bubble,
    output logic             o_flush_if_id,
    output logic             o_flush_id_reg,
    output logic             o_flush_reg_ex,
    output logic             o_flush_ex_mem,
    output logic             o_pc_redirect,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count,
    output logic [1:0]       o_ctrl_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_t      r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_rs_match;
    logic w_rt_match;
    logic w_hazard;
    logic w_in_flush;
    logic w_branch;
    logic w_stall;
    logic w_new_vld;

    assign w_new_vld = i_id_valid & i_id_reg_write & (i_id_dest != 5'd0);

    hazard_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (w_branch),
        .i_bubble   (w_stall),
        .i_new_vld  (w_new_vld),
        .i_new_dest (i_id_dest),
        .i_rs       (i_id_rs),
        .i_rt       (i_id_rt),
        .o_rs_match (w_rs_match),
        .o_rt_match (w_rt_match)
    );

    assign w_hazard = i_id_valid & (w_rs_match | (i_id_uses_rt & w_rt_match));

    // The cycle after a flush IF_ID holds a bubble and EX_MEM was cleared,
    // so neither a hazard nor a branch from that cycle is real.
    assign w_in_flush = (r_state == FLUSH);

    // Branch outranks the hazard: the stalled ID instruction is discarded anyway.
    assign w_branch = !i_reset && !w_in_flush && i_mem_branch_taken;
    assign w_stall  = !i_reset && !w_in_flush && !i_mem_branch_taken && w_hazard;

    assign o_pc_hold       = w_stall;
    assign o_if_id_hold    = w_stall;
    assign o_id_reg_bubble = w_stall;
    assign o_flush_if_id   = w_branch;
    assign o_flush_id_reg  = w_branch;
    assign o_flush_reg_ex  = w_branch;
    assign o_flush_ex_mem  = w_branch;
    assign o_pc_redirect   = w_branch;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_branch) begin
            r_state <= FLUSH;
            if (r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end else if (w_stall) begin
            r_state <= STALL;
            if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end else begin
            r_state <= RUN;
        end
    end

    assign o_stall_count = r_stall_cnt;
    assign o_flush_count = r_flush_cnt;
    assign o_ctrl_state  = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances share one input stream
// (bypass on, bypass off, bypass on with 4-bit counters).
module tb_hazard_ctrl;

    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] HOLD = 8'hE0;
    localparam logic [7:0] BR   = 8'h1F;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       id_uses_rt = 1'b0;
    logic [4:0] id_dest = 5'd0;
    logic       id_reg_write = 1'b0;
    logic       br = 1'b0;

    // Control bits: {pc_hold, if_id_hold, bubble, fl_if_id, fl_id_reg, fl_reg_ex, fl_ex_mem, redirect}
    logic [7:0]  c1, c0, cs;
    logic [1:0]  s1, s0, ss;
    logic [15:0] sc1, fc1, sc0, fc0;
    logic [3:0]  scs, fcs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] e1;
        logic [1:0] es1;
        logic [7:0] e0;
        logic [1:0] es0;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) u_b1 (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_id_dest(id_dest), .i_id_reg_write(id_reg_write),
        .i_mem_branch_taken(br),
        .o_pc_hold(c1[7]), .o_if_id_hold(c1[6]), .o_id_reg_bubble(c1[5]),
        .o_flush_if_id(c1[4]), .o_flush_id_reg(c1[3]), .o_flush_reg_ex(c1[2]),
        .o_flush_ex_mem(c1[1]), .o_pc_redirect(c1[0]),
        .o_stall_count(sc1), .o_flush_count(fc1), .o_ctrl_state(s1)
    );

    hazard_ctrl #(.WB_BYPASS(0), .CNT_W(16)) u_b0 (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_id_dest(id_dest), .i_id_reg_write(id_reg_write),
        .i_mem_branch_taken(br),
        .o_pc_hold(c0[7]), .o_if_id_hold(c0[6]), .o_id_reg_bubble(c0[5]),
        .o_flush_if_id(c0[4]), .o_flush_id_reg(c0[3]), .o_flush_reg_ex(c0[2]),
        .o_flush_ex_mem(c0[1]), .o_pc_redirect(c0[0]),
        .o_stall_count(sc0), .o_flush_count(fc0), .o_ctrl_state(s0)
    );

    hazard_ctrl #(.WB_BYPASS(1), .CNT_W(4)) u_sat (
        .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(id_uses_rt), .i_id_dest(id_dest), .i_id_reg_write(id_reg_write),
        .i_mem_branch_taken(br),
        .o_pc_hold(cs[7]), .o_if_id_hold(cs[6]), .o_id_reg_bubble(cs[5]),
        .o_flush_if_id(cs[4]), .o_flush_id_reg(cs[3]), .o_flush_reg_ex(cs[2]),
        .o_flush_ex_mem(cs[1]), .o_pc_redirect(cs[0]),
        .o_stall_count(scs), .o_flush_count(fcs), .o_ctrl_state(ss)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID/MEM input set, queue the expected outputs, compare at the falling edge.
    task automatic cyc(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] dest, input logic rw, input logic b,
                       input logic rst, input logic [7:0] e1, input logic [1:0] es1,
                       input logic [7:0] e0, input logic [1:0] es0);
        exp_t e;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; br = b; reset = rst;
        e.tag = tag; e.e1 = e1; e.es1 = es1; e.e0 = e0; e.es0 = es0;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk({e.tag, "/b1_ctl"},  {8'h0, c1}, {8'h0, e.e1});
        chk({e.tag, "/b1_st"},   {14'h0, s1}, {14'h0, e.es1});
        chk({e.tag, "/b0_ctl"},  {8'h0, c0}, {8'h0, e.e0});
        chk({e.tag, "/b0_st"},   {14'h0, s0}, {14'h0, e.es0});
        chk({e.tag, "/sat_ctl"}, {8'h0, cs}, {8'h0, e.e1});
        chk({e.tag, "/sat_st"},  {14'h0, ss}, {14'h0, e.es1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, NONE, S_RUN, NONE, S_RUN);
    endtask

    task automatic chk_cnt(input string tag, input int st1, input int st0, input int sts,
                           input int fl);
        chk({tag, "/stall_b1"},  sc1, st1[15:0]);
        chk({tag, "/stall_b0"},  sc0, st0[15:0]);
        chk({tag, "/stall_sat"}, {12'h0, scs}, sts[15:0]);
        chk({tag, "/flush_b1"},  fc1, fl[15:0]);
        chk({tag, "/flush_b0"},  fc0, fl[15:0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e1, e0;
        logic [1:0] es1, es0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset dominates a branch request and a would-be hazard.
        cyc("rst_force", 1, 3, 3, 1, 3, 1, 1, 1, NONE, S_RUN, NONE, S_RUN);
        chk_cnt("rst", 0, 0, 0, 0);

        // add $3 ; sub $5,$3,$4 held in ID until released
        cyc("dep_add",  1, 1, 2, 1, 3, 1, 0, 0, NONE, S_RUN,   NONE, S_RUN);
        cyc("dep_sub1", 1, 3, 4, 1, 5, 1, 0, 0, HOLD, S_RUN,   HOLD, S_RUN);
        cyc("dep_sub2", 1, 3, 4, 1, 5, 1, 0, 0, HOLD, S_STALL, HOLD, S_STALL);
        cyc("dep_sub3", 1, 3, 4, 1, 5, 1, 0, 0, NONE, S_STALL, HOLD, S_STALL);
        cyc("dep_sub4", 1, 3, 4, 1, 5, 1, 0, 0, NONE, S_RUN,   NONE, S_STALL);
        chk_cnt("dep", 2, 3, 2, 0);
        idle("drain1"); idle("drain2"); idle("drain3");

        // Independent and $0 cases, plus an rt match that is not read
        cyc("ind_add",  1, 1, 2, 1, 3, 1, 0, 0, NONE, S_RUN, NONE, S_RUN);
        cyc("ind_or",   1, 0, 7, 1, 6, 1, 0, 0, NONE, S_RUN, NONE, S_RUN);
        cyc("z_add0",   1, 1, 2, 1, 0, 1, 0, 0, NONE, S_RUN, NONE, S_RUN);
        cyc("z_use0",   1, 0, 0, 1, 8, 1, 0, 0, NONE, S_RUN, NONE, S_RUN);
        cyc("rt_unused",1, 1, 6, 0, 9, 1, 0, 0, NONE, S_RUN, NONE, S_RUN);
        // rt hazard, then a taken branch while the hazard persists
        cyc("rt_haz",   1, 0, 9, 1, 11, 1, 0, 0, HOLD, S_RUN,   HOLD, S_RUN);
        cyc("br_haz",   1, 0, 9, 1, 11, 1, 1, 0, BR,   S_STALL, BR,   S_STALL);
        cyc("br_flush", 0, 0, 0, 0, 0, 0, 1, 0, NONE, S_FLUSH, NONE, S_FLUSH);
        idle("br_run");
        chk_cnt("br", 3, 4, 3, 1);

        // Reset during the second stall cycle
        cyc("rs_add",  1, 1, 2, 1, 3, 1, 0, 0, NONE, S_RUN,   NONE, S_RUN);
        cyc("rs_sub1", 1, 3, 4, 1, 5, 1, 0, 0, HOLD, S_RUN,   HOLD, S_RUN);
        cyc("rs_sub2", 1, 3, 4, 1, 5, 1, 0, 1, NONE, S_STALL, NONE, S_STALL);
        cyc("rs_sub3", 1, 3, 4, 1, 5, 1, 0, 0, NONE, S_RUN,   NONE, S_RUN);
        chk_cnt("rs", 0, 0, 0, 0);
        idle("drain4"); idle("drain5"); idle("drain6");

        // add $3,$3,$3 repeated: self-dependent stream keeps re-stalling
        for (int k = 0; k < 30; k++) begin
            e1  = (k % 3 == 0) ? NONE : HOLD;
            es1 = ((k % 3 == 2) || (k % 3 == 0 && k > 0)) ? S_STALL : S_RUN;
            e0  = (k % 4 == 0) ? NONE : HOLD;
            es0 = ((k % 4 >= 2) || (k % 4 == 0 && k > 0)) ? S_STALL : S_RUN;
            cyc($sformatf("sat%0d", k), 1, 3, 3, 1, 3, 1, 0, 0, e1, es1, e0, es0);
        end
        chk_cnt("sat", 20, 22, 15, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the six-position MIPS pipeline: IF, ID, REG (register-file read), EX, MEM (branch resolve), WB. It has no forwarding paths, so it keeps a scoreboard of in-flight register writes and holds PC and IF_ID while an ID-stage consumer would read a stale register. On a taken branch resolved in MEM, it flushes every younger instruction. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `WB_BYPASS`, default 1: 1 means a register-file write in WB is visible to a same-cycle read in REG.
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: IF_ID holds a real instruction (not a bubble).
- `id_rs` in 5: source register of the ID instruction.
- `id_rt` in 5: second source register.
- `id_uses_rt` in 1: the ID instruction reads rt (R-type, store, branch).
- `id_dest` in 5: destination register, already muxed by reg_dest.
- `id_reg_write` in 1: the ID instruction writes the register file.
- `mem_branch_taken` in 1: branch and zero in MEM.
- `pc_hold` out 1: PC keeps its value this edge.
- `if_id_hold` out 1: IF_ID keeps its value this edge.
- `id_reg_bubble` out 1: ID_REG loads all-zero controls this edge.
- `flush_if_id`, `flush_id_reg`, `flush_reg_ex`, `flush_ex_mem` out 1 each: the named register loads all-zero controls this edge.
- `pc_redirect` out 1: PC loads the branch target (PC mux select).
- `stall_count` out CNT_W: cycles spent stalling.
- `flush_count` out CNT_W: taken-branch flush events.
- `ctrl_state` out 2: current FSM state, for debug.

## Operation
- **Scoreboard.** Three entries, REG, EX and MEM, each holding {valid, dest}. Each entry mirrors the instruction held in the ID_REG, REG_EX or EX_MEM register respectively.
- **Scoreboard shift, every edge.** MEM←EX, EX←REG, REG←new.
  - new = {id_valid & id_reg_write & (id_dest≠0), id_dest} when ID advances.
  - new = invalid when a bubble or flush is inserted.
- **Match.** A source reg r matches when r≠0 and it equals a valid entry in the check set.
  - Check set is {REG, EX} when WB_BYPASS=1.
  - Check set is {REG, EX, MEM} when WB_BYPASS=0.
- **Hazard.** hazard = id_valid & (match(id_rs) | (id_uses_rt & match(id_rt))).
- **FSM states:** RUN=0, STALL=1, FLUSH=2.
- **Priority:** mem_branch_taken > hazard > advance.
- **Branch taken (RUN or STALL).**
  - Assert pc_redirect and all four flush_* outputs.
  - pc_hold and if_id_hold are 0.
  - REG and EX entries load invalid; MEM loads invalid through the shift.
  - Next state is FLUSH.
  - flush_count increments.
- **Hazard without branch.**
  - Assert pc_hold, if_id_hold and id_reg_bubble.
  - Next state is STALL.
  - stall_count increments.
- **Otherwise:** all outputs are 0 and next state is RUN.
- **FLUSH state.**
  - Lasts one cycle; returns to RUN unconditionally.
  - Hazard evaluation is suppressed, because IF_ID holds a bubble.
  - mem_branch_taken is ignored, because EX_MEM was flushed.
- **Counters** saturate at all-ones and never wrap.
- **Reset.** State goes to RUN, all entries go invalid, both counters go to 0.
  - While reset is high, every hold, bubble, flush and redirect output is forced to 0.

## Timing
- All control outputs are combinational (Mealy) from the registered scoreboard, the state and the same-cycle ID/MEM inputs. They act on the next rising edge.
- Stall length is the number of edges until the producer leaves the check set:
  - producer in REG: 2 cycles with WB_BYPASS=1, 3 with WB_BYPASS=0;
  - producer in EX: 1 cycle with WB_BYPASS=1, 2 with WB_BYPASS=0.
- Branch penalty is 4 instruction slots: the IF, ID, REG and EX instructions are discarded. The target is fetched on the edge where the flushes are asserted.
- Branch and hazard in the same cycle: the branch wins. No hold is asserted, and the stalled ID instruction is flushed.
- Reset asserted mid-stall or mid-flush: the state is RUN on the next edge, with no residual hold.
- $0 as a destination never creates a scoreboard entry. $0 as a source never matches.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the `ctrl_state_t` enum (RUN, STALL, FLUSH);
  - the `sb_entry_t` struct {valid, dest[4:0]};
  - the stage index constants SB_REG=0, SB_EX=1, SB_MEM=2.
- Sub-module `hazard_scoreboard` holds the 3-entry shift register, the per-entry invalidate/insert control and the match compare. `hazard_ctrl` holds the FSM, the output decode and the counters.

## Test plan
- **Back-to-back dependency, WB_BYPASS=1.** add $3 then sub $5,$3,$4 → pc_hold high for exactly 2 cycles; stall_count=2; sub enters REG when add is in WB.
- **Same stimulus, WB_BYPASS=0** → 3-cycle stall; stall_count=3.
- **Independent instruction, or $0 source.** add $3 then or $6,$0,$7; then add $0 then use $0 → no hold, no bubble in either case.
- **Taken branch.** Branch in MEM with mem_branch_taken=1 while ID has a hazard → all four flushes and pc_redirect asserted, no hold; one FLUSH cycle, then RUN; flush_count=1.
- **Reset mid-stall.** Assert reset during the second STALL cycle → next cycle ctrl_state=0, all outputs 0, counters 0, and the scoreboard is empty: the previously conflicting ID instruction now advances.
- **Saturation.** With CNT_W=4, a 20-cycle forced-hazard sequence → stall_count holds at 15.
